// File: rtl/ame_div_pkg.sv
// Shared types and sizing helpers for the AME signed fixed-point divider.
// The optional rounding build is selected with the AME_DIV_ROUND_EN macro in ame_num_divide.sv.
package ame_div_pkg;

  // Operands carry 48 significant bits (sign plus 47 magnitude bits).
  localparam int OPND_BITS = 48;
  // The partial remainder keeps one extra bit so the trial compare never overflows.
  localparam int REM_BITS  = 49;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    SIGN
  } div_state_t;

  // Number of restoring iterations: the shifted dividend below its top bit.
  function automatic int div_mag_width(input int frac_bits);
    return OPND_BITS - 1 + frac_bits;
  endfunction

endpackage

// File: rtl/ame_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The remainder entering a step is always below the divisor (at most 2^47),
// so its top bit is zero and the shifted trial value fits in REM_BITS.
module ame_div_step
  import ame_div_pkg::*;
(
  input  logic [REM_BITS-1:0]  rem,
  input  logic [OPND_BITS-1:0] divisor,
  input  logic                 dvd_bit,
  output logic [REM_BITS-1:0]  rem_next,
  output logic                 q_bit
);

  logic [REM_BITS-1:0] trial;
  logic [REM_BITS-1:0] divisor_ext;
  logic                unused_rem_msb;

  assign trial          = {rem[REM_BITS-2:0], dvd_bit};
  assign divisor_ext    = {1'b0, divisor};
  assign q_bit          = (trial >= divisor_ext);
  assign rem_next       = q_bit ? (trial - divisor_ext) : trial;
  assign unused_rem_msb = rem[REM_BITS-1];

endmodule

// File: rtl/ame_num_divide.sv
// Sequential signed fixed-point divider: Q = (N << FRAC_BITS) / D.
// Radix-2 restoring, one quotient bit per RUN cycle, init/done pulse handshake.
// Optional macro AME_DIV_ROUND_EN: round half away from zero instead of truncating.
module ame_num_divide
  import ame_div_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int FRAC_BITS      = 16
)
(
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           div_init_i,
  input  logic [1:0][COMP_DATA_BITS-1:0] div_data_i,
  output logic                           div_busy_o,
  output logic                           div_done_o,
  output logic                           div_zero_o,
  output logic [COMP_DATA_BITS-1:0]      div_data_o
);

  localparam int W        = div_mag_width(FRAC_BITS);
  // The quotient keeps one bit above W: only N = -2^47 reaches it (|N| << FRAC = 2^(W)).
  localparam int MAG_BITS = W + 1;
  localparam int CNT_BITS = $clog2(W);

  div_state_t state_reg, state_next;

  logic [OPND_BITS-1:0]      n_reg, d_reg;
  logic [OPND_BITS-1:0]      abs_d_reg;
  logic                      neg_reg;
  logic                      zero_reg;
  logic [W-1:0]              dvd_reg;
  logic [MAG_BITS-1:0]       quo_reg;
  logic [REM_BITS-1:0]       rem_reg;
  logic [CNT_BITS-1:0]       cnt_reg;
  logic                      busy_reg, done_reg, zero_out_reg;
  logic [COMP_DATA_BITS-1:0] data_reg;

  logic [OPND_BITS-1:0]      n_in, d_in;
  logic [OPND_BITS-1:0]      abs_n, abs_d;
  logic [MAG_BITS-1:0]       dvd_full;
  logic                      dvd_top;
  logic                      d_is_zero, d_is_one;
  logic                      accept;
  logic [REM_BITS-1:0]       step_rem;
  logic                      step_q;
  logic                      round_up;
  logic [COMP_DATA_BITS-1:0] mag_ext, signed_res;
  logic                      unused_opnd_bits;

  // Operand extraction: keep the sign and the low 47 bits; bits 62:47 are don't-care.
  assign n_in = {div_data_i[1][COMP_DATA_BITS-1], div_data_i[1][OPND_BITS-2:0]};
  assign d_in = {div_data_i[0][COMP_DATA_BITS-1], div_data_i[0][OPND_BITS-2:0]};
  assign unused_opnd_bits = ^{div_data_i[1][COMP_DATA_BITS-2:OPND_BITS-1],
                              div_data_i[0][COMP_DATA_BITS-2:OPND_BITS-1]};

  // Magnitudes; -(-2^47) wraps to 2^47 which is exactly right as an unsigned value.
  assign abs_n     = n_reg[OPND_BITS-1] ? -n_reg : n_reg;
  assign abs_d     = d_reg[OPND_BITS-1] ? -d_reg : d_reg;
  assign d_is_zero = (d_reg == '0);
  assign d_is_one  = (abs_d == OPND_BITS'(1));
  assign dvd_full  = MAG_BITS'(abs_n) << FRAC_BITS;
  assign dvd_top   = dvd_full[MAG_BITS-1];

  // A new job is taken when idle or on the final SIGN cycle of the previous one.
  assign accept = div_init_i && ((state_reg == IDLE) || (state_reg == SIGN));

  ame_div_step u_step (
    .rem      (rem_reg),
    .divisor  (abs_d_reg),
    .dvd_bit  (dvd_reg[W-1]),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

`ifdef AME_DIV_ROUND_EN
  assign round_up = ({rem_reg, 1'b0} >= {2'b00, abs_d_reg});
`else
  assign round_up = 1'b0;
`endif

  assign mag_ext    = COMP_DATA_BITS'(quo_reg) + COMP_DATA_BITS'(round_up);
  assign signed_res = neg_reg ? -mag_ext : mag_ext;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (div_init_i) state_next = LOAD;
      LOAD: state_next = d_is_zero ? SIGN : RUN;
      RUN:  if (cnt_reg == '0) state_next = SIGN;
      SIGN: state_next = div_init_i ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Datapath: operand capture, restoring iterations, sign application and outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      n_reg        <= '0;
      d_reg        <= '0;
      abs_d_reg    <= '0;
      neg_reg      <= 1'b0;
      zero_reg     <= 1'b0;
      dvd_reg      <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      zero_out_reg <= 1'b0;
      data_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          neg_reg   <= n_reg[OPND_BITS-1] ^ d_reg[OPND_BITS-1];
          abs_d_reg <= abs_d;
          zero_reg  <= d_is_zero;
          dvd_reg   <= dvd_full[W-1:0];
          cnt_reg   <= CNT_BITS'(W - 1);
          // Resolve the dividend's top bit here so RUN only needs W iterations.
          // With a nonzero divisor it yields quotient 1 only when |D| == 1.
          quo_reg   <= MAG_BITS'(dvd_top & d_is_one);
          rem_reg   <= REM_BITS'(dvd_top & ~d_is_one);
        end
        RUN: begin
          rem_reg <= step_rem;
          quo_reg <= {quo_reg[MAG_BITS-2:0], step_q};
          dvd_reg <= {dvd_reg[W-2:0], 1'b0};
          cnt_reg <= cnt_reg - CNT_BITS'(1);
        end
        SIGN: begin
          data_reg     <= zero_reg ? '0 : signed_res;
          zero_out_reg <= zero_reg;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
        end
        default: ;
      endcase
      if (accept) begin
        n_reg    <= n_in;
        d_reg    <= d_in;
        busy_reg <= 1'b1;
      end
    end
  end

  assign div_busy_o = busy_reg;
  assign div_done_o = done_reg;
  assign div_zero_o = zero_out_reg;
  assign div_data_o = data_reg;

endmodule

// File: tb/tb_ame_num_divide.sv
// Directed self-checking bench for ame_num_divide (default FRAC_BITS = 16).
// Build with AME_DIV_ROUND_EN defined to check the rounding variant.
module tb_ame_num_divide;

  logic             clk;
  logic             rst_n;
  logic             div_init;
  logic [1:0][63:0] div_data;
  logic             div_busy;
  logic             div_done;
  logic             div_zero;
  logic [63:0]      div_q;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef AME_DIV_ROUND_EN
  localparam logic [63:0] EXP_2_3   = 64'd43691;
  localparam logic [63:0] EXP_MAXMN = 64'hFFFF_FFFF_FFFF_0000;  // -65536
`else
  localparam logic [63:0] EXP_2_3   = 64'd43690;
  localparam logic [63:0] EXP_MAXMN = 64'hFFFF_FFFF_FFFF_0001;  // -65535
`endif

  ame_num_divide #(.COMP_DATA_BITS(64), .FRAC_BITS(16)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .div_init_i (div_init),
    .div_data_i (div_data),
    .div_busy_o (div_busy),
    .div_done_o (div_done),
    .div_zero_o (div_zero),
    .div_data_o (div_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Issue one job, then watch for done within a bounded number of edges.
  task automatic run_job(input string tag, input logic [63:0] n, input logic [63:0] d,
                         input logic [63:0] exp_q, input logic exp_z, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    div_init    = 1'b1;
    div_data[1] = n;
    div_data[0] = d;
    @(posedge clk); #1;
    div_init = 1'b0;
    check({tag, "_busy"}, 64'(div_busy), 64'd1);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (div_done) seen = 1;
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_q"}, div_q, exp_q);
    check({tag, "_zero"}, 64'(div_zero), 64'(exp_z));
    $display("job %s: N=0x%h D=0x%h -> Q=0x%h zero=%b lat=%0d", tag, n, d, div_q, div_zero, lat);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(div_done), 64'd0);
  endtask

  initial begin
    int ndone, first_lat, second_lat;
    logic [63:0] first_q, second_q;

    rst_n    = 1'b0;
    div_init = 1'b0;
    div_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(div_busy), 64'd0);
    check("rst_done", 64'(div_done), 64'd0);
    check("rst_zero", 64'(div_zero), 64'd0);
    check("rst_q", div_q, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run_job("n3_d2",    64'd3,                  64'd2,                  64'd98304,              1'b0, 65);
    run_job("nm7_d2",   64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFC_8000, 1'b0, 65);
    run_job("n7_dm2",   64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFC_8000, 1'b0, 65);
    run_job("nm7_dm2",  64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd229376,           1'b0, 65);
    run_job("n2_d3",    64'd2,                  64'd3,                  EXP_2_3,                1'b0, 65);
    run_job("n1_d3",    64'd1,                  64'd3,                  64'd21845,              1'b0, 65);
    run_job("n5_d0",    64'd5,                  64'd0,                  64'd0,                  1'b1, 2);
    run_job("n4_d2",    64'd4,                  64'd2,                  64'd131072,             1'b0, 65);
    run_job("nmin_d1",  64'hFFFF_8000_0000_0000, 64'd1,                 64'h8000_0000_0000_0000, 1'b0, 65);
    run_job("nmax_dmin", 64'h0000_7FFF_FFFF_FFFF, 64'hFFFF_8000_0000_0000, EXP_MAXMN,          1'b0, 65);
    run_job("garb_pos", 64'h7FFF_8000_0000_0003, 64'h7FFF_8000_0000_0002, 64'd98304,           1'b0, 65);
    run_job("garb_neg", 64'h2AAA_8000_0000_0007, 64'h8000_7FFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFC_8000, 1'b0, 65);

    // Second init while busy must be ignored.
    @(negedge clk);
    div_init = 1'b1; div_data[1] = 64'd3; div_data[0] = 64'd2;
    @(posedge clk); #1;
    div_init  = 1'b0;
    ndone     = 0;
    first_lat = 0;
    first_q   = '0;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      if (div_done) begin
        ndone++;
        if (ndone == 1) begin first_lat = i; first_q = div_q; end
      end
      if (i == 10) begin div_init = 1'b1; div_data[1] = 64'd1; div_data[0] = 64'd3; end
      if (i == 11) div_init = 1'b0;
    end
    check("busy_ign_count", 64'(ndone), 64'd1);
    check("busy_ign_lat", 64'(first_lat), 64'd65);
    check("busy_ign_q", first_q, 64'd98304);
    $display("job busy_ignore: dones=%0d lat=%0d Q=0x%h", ndone, first_lat, first_q);

    // Back-to-back: second init sampled on the SIGN edge of the first job.
    @(negedge clk);
    div_init = 1'b1; div_data[1] = 64'hFFFF_FFFF_FFFF_FFF9; div_data[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    @(posedge clk); #1;
    div_init   = 1'b0;
    second_lat = 0;
    second_q   = '0;
    for (int i = 1; i <= 160 && second_lat == 0; i++) begin
      @(posedge clk); #1;
      if (i == 65) begin
        div_init = 1'b0;
        check("b2b_first_done", 64'(div_done), 64'd1);
        check("b2b_first_q", div_q, 64'd229376);
        check("b2b_busy", 64'(div_busy), 64'd1);
      end else if (div_done && i > 65) begin
        second_lat = i - 65;
        second_q   = div_q;
      end
      if (i == 64) begin div_init = 1'b1; div_data[1] = 64'd1; div_data[0] = 64'd3; end
    end
    check("b2b_second_lat", 64'(second_lat), 64'd65);
    check("b2b_second_q", second_q, 64'd21845);
    $display("job back_to_back: second lat=%0d Q=0x%h", second_lat, second_q);

    // Reset in the middle of RUN aborts the job without a done pulse.
    @(negedge clk);
    div_init = 1'b1; div_data[1] = 64'd7; div_data[0] = 64'd2;
    @(posedge clk); #1;
    div_init = 1'b0;
    repeat (21) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_q", div_q, 64'd0);
    check("rstmid_busy", 64'(div_busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (div_done) ndone++;
    end
    check("rstmid_nodone", 64'(ndone), 64'd0);
    $display("job reset_mid_run: Q=0x%h busy=%b dones=%0d", div_q, div_busy, ndone);
    @(negedge clk) rst_n = 1'b1;
    run_job("post_rst", 64'd3, 64'd2, 64'd98304, 1'b0, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
